// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE sequencer: FSM state encoding,
// watchdog widths and the job-legality rule.
package pe_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_GAP,
    S_START,
    S_COMPUTE,
    S_SUMS_WAIT,
    S_SUMS,
    S_SUMS_END
  } state_e;

  localparam int TIMEOUT_W    = 16;
  localparam int SUMS_END_MAX = 4;

  // A job needs at least one tap, no more taps than activations, and must fit the spads.
  function automatic logic cmd_legal(input int unsigned k, input int unsigned n,
                                     input int unsigned depth);
    return (k >= 1) && (k <= n) && (n <= depth);
  endfunction

endpackage

// File: rtl/seq_buf.sv
// Small register file holding one buffered stream: synchronous write,
// combinational read so a burst can be replayed one entry per cycle.
module seq_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every entry is written in FILL before LOAD reads it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_sequencer.sv
// Job controller for one 1D-convolution PE: buffers weight/activation streams,
// replays them as gap-free load bursts, starts compute and runs the sum phase.
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_wcount,
  input  logic [CNT_W-1:0]  cmd_acount,
  input  logic              cmd_sums_en,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] pe_weights,
  output logic [DATA_W-1:0] pe_acts,
  output logic              pe_loadw,
  output logic              pe_loada,
  output logic              pe_start,
  output logic              pe_sums,
  output logic [CNT_W-1:0]  pe_wcount,
  output logic [CNT_W-1:0]  pe_acount,
  input  logic              pe_flag_done,
  input  logic              sums_go,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  state_e               state;
  logic                 sums_en_q;
  logic [CNT_W-1:0]     wcnt, acnt, ridx, srem;
  logic [CNT_W-1:0]     wcnt_nx, acnt_nx;
  logic [TIMEOUT_W-1:0] timer;
  logic                 w_hs, a_hs;
  logic [DATA_W-1:0]    wbuf_rd, abuf_rd;

  // Ready is only ever raised in FILL, so a handshake implies FILL.
  assign w_hs = w_valid & w_ready;
  assign a_hs = a_valid & a_ready;

  always_comb begin
    wcnt_nx = wcnt + CNT_W'(w_hs);
    acnt_nx = acnt + CNT_W'(a_hs);
  end

  seq_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_wbuf (
    .clk   (clk),
    .we    (w_hs),
    .waddr (wcnt[AW-1:0]),
    .wdata (w_data),
    .raddr (ridx[AW-1:0]),
    .rdata (wbuf_rd)
  );

  seq_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_abuf (
    .clk   (clk),
    .we    (a_hs),
    .waddr (acnt[AW-1:0]),
    .wdata (a_data),
    .raddr (ridx[AW-1:0]),
    .rdata (abuf_rd)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      sums_en_q  <= 1'b0;
      wcnt       <= '0;
      acnt       <= '0;
      ridx       <= '0;
      srem       <= '0;
      timer      <= '0;
      cmd_ready  <= 1'b1;
      w_ready    <= 1'b0;
      a_ready    <= 1'b0;
      pe_weights <= '0;
      pe_acts    <= '0;
      pe_loadw   <= 1'b0;
      pe_loada   <= 1'b0;
      pe_start   <= 1'b0;
      pe_sums    <= 1'b0;
      pe_wcount  <= '0;
      pe_acount  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; a later assignment in this block wins for one cycle.
      done <= 1'b0;
      err  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pe_wcount <= cmd_wcount;
            pe_acount <= cmd_acount;
            sums_en_q <= cmd_sums_en;
            if (cmd_legal(32'(cmd_wcount), 32'(cmd_acount), DEPTH)) begin
              state     <= S_FILL;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              w_ready   <= 1'b1;
              a_ready   <= 1'b1;
              wcnt      <= '0;
              acnt      <= '0;
              ridx      <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_FILL: begin
          wcnt    <= wcnt_nx;
          acnt    <= acnt_nx;
          w_ready <= (wcnt_nx < pe_wcount);
          a_ready <= (acnt_nx < pe_acount);
          // Entry 0 is presented on the transition so both bursts begin together.
          if (wcnt == pe_wcount && acnt == pe_acount) begin
            state      <= S_LOAD;
            pe_loadw   <= 1'b1;
            pe_loada   <= 1'b1;
            pe_weights <= wbuf_rd;
            pe_acts    <= abuf_rd;
            ridx       <= CNT_W'(1);
          end
        end

        S_LOAD: begin
          ridx       <= ridx + CNT_W'(1);
          pe_loadw   <= (ridx < pe_wcount);
          pe_weights <= (ridx < pe_wcount) ? wbuf_rd : '0;
          pe_loada   <= (ridx < pe_acount);
          pe_acts    <= (ridx < pe_acount) ? abuf_rd : '0;
          if (ridx >= pe_acount) state <= S_GAP;
        end

        S_GAP: begin
          state    <= S_START;
          pe_start <= 1'b1;
        end

        S_START: begin
          state    <= S_COMPUTE;
          pe_start <= 1'b0;
          timer    <= '0;
        end

        S_COMPUTE: begin
          if (pe_flag_done) begin
            if (sums_en_q) begin
              state <= S_SUMS_WAIT;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
            end
          end else if (timer == '1) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            err       <= 1'b1;
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end

        S_SUMS_WAIT: begin
          if (sums_go) begin
            state   <= S_SUMS;
            pe_sums <= 1'b1;
            srem    <= pe_acount - pe_wcount;
          end
        end

        // One sum cycle per output position; sums_go is no longer looked at.
        S_SUMS: begin
          if (srem == '0) begin
            state   <= S_SUMS_END;
            pe_sums <= 1'b0;
            timer   <= '0;
          end else begin
            srem <= srem - CNT_W'(1);
          end
        end

        S_SUMS_END: begin
          if (pe_flag_done) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
          end else if (timer == TIMEOUT_W'(SUMS_END_MAX - 1)) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            err       <= 1'b1;
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized self-checking bench for pe_sequencer: per-cycle PE-side trace
// compared against a job-level timing model built from handshake cycles.
module tb_pe_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_sums_en = 1'b0;
  logic [CNT_W-1:0]  cmd_wcount = '0, cmd_acount = '0;
  logic              w_valid = 1'b0, w_ready, a_valid = 1'b0, a_ready;
  logic [DATA_W-1:0] w_data = '0, a_data = '0;
  logic [DATA_W-1:0] pe_weights, pe_acts;
  logic              pe_loadw, pe_loada, pe_start, pe_sums;
  logic [CNT_W-1:0]  pe_wcount, pe_acount;
  logic              pe_flag_done = 1'b0, sums_go = 1'b0;
  logic              busy, done, err;

  pe_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wcount(cmd_wcount),
    .cmd_acount(cmd_acount), .cmd_sums_en(cmd_sums_en),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_weights(pe_weights), .pe_acts(pe_acts),
    .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
    .pe_wcount(pe_wcount), .pe_acount(pe_acount),
    .pe_flag_done(pe_flag_done), .sums_go(sums_go),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current job description and the bench-side event times it produced.
  int jid = 0;
  int jk, jn, jstall, cdel, gdel;
  bit jsums, jlegal, jhold;
  int cmd_cyc, w_last, a_last, flag_cyc, go_cyc, flag2_cyc;
  logic [DATA_W-1:0] wv [DEPTH];
  logic [DATA_W-1:0] av [DEPTH];

  typedef struct { int c; logic [23:0] v; } samp_t;
  samp_t tr[$];

  function automatic logic [23:0] obs_vec();
    return {busy, cmd_ready, done, err, pe_loadw, pe_loada, pe_start, pe_sums, pe_weights, pe_acts};
  endfunction

  // Expected cycle-c view of the outputs, from the job rules alone.
  function automatic logic [23:0] exp_vec(input int c);
    bit b, d, e, lw, la, st, sm;
    logic [DATA_W-1:0] wd, ad;
    int l0, s0, end_c;
    b = 0; d = 0; e = 0; lw = 0; la = 0; st = 0; sm = 0; wd = '0; ad = '0;
    if (!jlegal) begin
      e = (c == cmd_cyc + 1);
    end else begin
      l0 = ((w_last > a_last) ? w_last : a_last) + 2;
      s0 = l0 + jn + 1;
      end_c = jhold ? s0 + 65536 : (jsums ? flag2_cyc : flag_cyc);
      b  = (c > cmd_cyc) && (c <= end_c);
      d  = !jhold && (c == end_c + 1);
      e  = jhold && (c == end_c + 1);
      lw = (c >= l0) && (c < l0 + jk);
      la = (c >= l0) && (c < l0 + jn);
      if (lw) wd = wv[c - l0];
      if (la) ad = av[c - l0];
      st = (c == s0);
      sm = jsums && (c > go_cyc) && (c <= go_cyc + jn - jk + 1);
    end
    return {b, !b, d, e, lw, la, st, sm, wd, ad};
  endfunction

  task automatic set_stream(input bit is_w, input bit v, input logic [DATA_W-1:0] d);
    if (is_w) begin w_valid = v; w_data = d; end
    else      begin a_valid = v; a_data = d; end
  endtask

  task automatic drive_stream(input bit is_w);
    int cnt, g;
    bit hs, ok;
    cnt = is_w ? jk : jn;
    ok = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, jstall)) begin
        set_stream(is_w, 1'b0, '0);
        step();
      end
      set_stream(is_w, 1'b1, is_w ? wv[i] : av[i]);
      g = 0;
      do begin
        hs = is_w ? w_ready : a_ready;
        if (hs) begin
          if (is_w) w_last = cyc;
          else      a_last = cyc;
        end
        step();
        g++;
      end while (!hs && g < 300);
      ok &= hs;
    end
    set_stream(is_w, 1'b0, '0);
    check($sformatf("job%0d %s stream accepted", jid, is_w ? "w" : "a"), 64'(ok), 64'(1));
  endtask

  // Stub PE: answers pe_start with flag_done, grants the sum phase, then flags its end.
  task automatic pe_stub();
    int g = 0;
    while (!pe_start && g < 400) begin step(); g++; end
    if (pe_start && !jhold) begin
      repeat (cdel) step();
      pe_flag_done = 1'b1; flag_cyc = cyc; step(); pe_flag_done = 1'b0;
      if (jsums) begin
        repeat (gdel) step();
        sums_go = 1'b1; go_cyc = cyc; step(); sums_go = 1'b0;
        g = 0;
        while (!pe_sums && g < 50) begin step(); g++; end
        while (pe_sums && g < 100) begin step(); g++; end
        pe_flag_done = 1'b1; flag2_cyc = cyc; step(); pe_flag_done = 1'b0;
      end
    end
  endtask

  task automatic monitor(input int budget);
    int g = 0;
    bit fin;
    tr.delete();
    do begin
      @(negedge clk);
      tr.push_back('{cyc, obs_vec()});
      fin = done | err;
      g++;
    end while (!fin && g < budget);
    check($sformatf("job%0d terminated", jid), 64'(fin), 64'(1));
    repeat (2) begin
      @(negedge clk);
      tr.push_back('{cyc, obs_vec()});
    end
  endtask

  task automatic send_cmd(input int k, input int n, input bit s);
    int g = 0;
    while (!cmd_ready && g < 100) begin step(); g++; end
    check($sformatf("job%0d cmd_ready", jid), 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_wcount = CNT_W'(k);
    cmd_acount = CNT_W'(n);
    cmd_sums_en = s;
    cmd_cyc = cyc;
  endtask

  task automatic run_job(input int k, input int n, input bit s, input int stall, input int cd,
                         input int gd, input bit hold, input bit fixed, input int budget);
    jid++;
    jk = k; jn = n; jsums = s; jstall = stall; cdel = cd; gdel = gd; jhold = hold;
    jlegal = (k >= 1) && (k <= n) && (n <= DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      wv[i] = fixed ? DATA_W'(i + 1) : DATA_W'($urandom_range(1, 255));
      av[i] = fixed ? DATA_W'(i + 4) : DATA_W'($urandom_range(1, 255));
    end
    w_last = 0; a_last = 0; flag_cyc = -1; flag2_cyc = -1; go_cyc = -100;
    send_cmd(k, n, s);
    fork
      monitor(budget);
      begin step(); cmd_valid = 1'b0; end
      begin if (jlegal) drive_stream(1'b1); end
      begin if (jlegal) drive_stream(1'b0); end
      begin if (jlegal) pe_stub(); end
    join
    check($sformatf("job%0d pe_wcount", jid), 64'(pe_wcount), 64'(k[CNT_W-1:0]));
    check($sformatf("job%0d pe_acount", jid), 64'(pe_acount), 64'(n[CNT_W-1:0]));
    foreach (tr[i])
      check($sformatf("job%0d cyc+%0d", jid, tr[i].c - cmd_cyc), 64'(tr[i].v), 64'(exp_vec(tr[i].c)));
    step();
  endtask

  initial begin
    int k, n, g;
    #2 nrst = 1'b0;
    #2;
    check("reset ctl", 64'({cmd_ready, w_ready, a_ready, pe_loadw, pe_loada, pe_start, pe_sums,
                             busy, done, err}), 64'(10'b1000000000));
    check("reset data", 64'({pe_weights, pe_acts, pe_wcount, pe_acount}), 64'(0));
    @(negedge clk) nrst = 1'b1;
    step();

    // Directed: plain job, stalled streams, delayed sum phase, illegal commands.
    run_job(3, 5, 1'b0, 0, 3, 0, 1'b0, 1'b1, 300);
    run_job(3, 5, 1'b0, 3, 2, 0, 1'b0, 1'b1, 300);
    run_job(3, 5, 1'b1, 1, 2, 10, 1'b0, 1'b1, 300);
    run_job(0, 5, 1'b0, 0, 1, 0, 1'b0, 1'b0, 20);
    run_job(6, 5, 1'b0, 0, 1, 0, 1'b0, 1'b0, 20);
    run_job(1, 17, 1'b0, 0, 1, 0, 1'b0, 1'b0, 20);
    run_job(16, 16, 1'b1, 2, 1, 3, 1'b0, 1'b0, 400);
    run_job(1, 1, 1'b1, 0, 1, 0, 1'b0, 1'b0, 100);

    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, DEPTH);
      n = $urandom_range(k, DEPTH);
      run_job(k, n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 5),
              $urandom_range(0, 5), 1'b0, 1'b0, 500);
    end

    // Reset in the middle of a load burst, then a normal job.
    jid++; jk = 4; jn = 7; jstall = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wv[i] = DATA_W'($urandom_range(1, 255));
      av[i] = DATA_W'($urandom_range(1, 255));
    end
    send_cmd(4, 7, 1'b1);
    fork
      drive_stream(1'b1);
      drive_stream(1'b0);
      begin step(); cmd_valid = 1'b0; end
    join
    g = 0;
    while (!pe_loadw && g < 50) begin step(); g++; end
    step(); step();
    check("pre-reset load active", 64'({pe_loadw, pe_loada}), 64'(2'b11));
    #2 nrst = 1'b0;
    #1;
    check("mid-load reset pe ctl", 64'({pe_loadw, pe_loada, pe_start, pe_sums, pe_weights, pe_acts}), 64'(0));
    check("mid-load reset status", 64'({busy, cmd_ready, done, err, w_ready, a_ready}), 64'(6'b010000));
    @(negedge clk) nrst = 1'b1;
    step();
    run_job(4, 7, 1'b1, 1, 2, 2, 1'b0, 1'b0, 400);

    // Compute watchdog: flag_done withheld.
    run_job(16, 16, 1'b0, 0, 1, 0, 1'b1, 1'b0, 66000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
